// File: rtl/gf_pkg.sv
// Shared definitions for the iterative GF(2^M) multiplier slice.
package gf_pkg;

    // Default field degree and counter width used by the controller.
    localparam int GF_M     = 32;
    localparam int GF_CNT_W = 6;

    // Reduction polynomial x^32 + x^7 + x^5 + x^3 + x^2 + x + 1 without the x^32 term.
    localparam logic [31:0] GF_POLY_DEFAULT = 32'h0000_00AF;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_row_step.sv
// One row of the GF(2^M) systolic multiplier: shift-and-reduce the running
// partial product, then add the multiplicand when the current multiplier bit is set.
module gf_row_step
    import gf_pkg::*;
#(
    parameter int M = GF_M
)
(
    input  logic [M-1:0] i_p,
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_g,
    input  logic         i_bi,
    output logic [M-1:0] o_pNext
);

    logic [M-1:0] w_shifted;
    logic [M-1:0] w_reduce;
    logic [M-1:0] w_addend;

    // Multiply by x, fold the overflowing x^M term back in as g, add a when b_i is set.
    always_comb begin
        w_shifted = {i_p[M-2:0], 1'b0};
        w_reduce  = i_p[M-1] ? i_g : '0;
        w_addend  = i_bi ? i_a : '0;
        o_pNext   = w_shifted ^ w_reduce ^ w_addend;
    end

endmodule

// File: rtl/gf_mult_seq_ctrl.sv
// Iterative GF(2^M) multiplier controller: one shared row-step datapath is
// reused for M cycles, walking b from its MSB down to bit 0.
module gf_mult_seq_ctrl
    import gf_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int CNT_W = GF_CNT_W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    input  logic [M-1:0] g_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p_out,
    output logic         busy
);

    localparam int             IDX_W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(M - 1);

    gf_state_e        r_state;
    logic [M-1:0]     r_p;
    logic [M-1:0]     r_a;
    logic [M-1:0]     r_b;
    logic [M-1:0]     r_g;
    logic [CNT_W-1:0] r_cnt;
    logic             r_outValid;
    logic [M-1:0]     r_pOut;

    logic             w_canAccept;
    logic             w_accept;
    logic             w_bi;
    logic             w_lastStep;
    logic [M-1:0]     w_pNext;

    // Handshake and status decode; everything is held quiet while reset is asserted.
    always_comb begin
        w_canAccept = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        in_ready    = w_canAccept & ~rst;
        w_accept    = in_valid & in_ready;
        w_bi        = r_b[r_cnt[IDX_W-1:0]];
        w_lastStep  = (r_cnt == '0);
        out_valid   = r_outValid & ~rst;
        busy        = (r_state != IDLE) & ~rst;
        p_out       = r_pOut;
    end

    gf_row_step #(
        .M (M)
    ) u_rowStep (
        .i_p     (r_p),
        .i_a     (r_a),
        .i_g     (r_g),
        .i_bi    (w_bi),
        .o_pNext (w_pNext)
    );

    // FSM, iteration counter and operand/accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_p        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_g        <= '0;
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_pOut     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_g     <= g_in;
                        r_p     <= '0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_p   <= w_pNext;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_lastStep) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_pOut     <= w_pNext;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_pOut     <= '0;
                        if (w_accept) begin
                            r_a     <= a_in;
                            r_b     <= b_in;
                            r_g     <= g_in;
                            r_p     <= '0;
                            r_cnt   <= CNT_LOAD;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mult_seq_ctrl.sv
// Self-checking bench for gf_mult_seq_ctrl: carry-less multiply-then-reduce
// reference model, per-cycle output comparison, directed and random operands.
module tb_gf_mult_seq_ctrl;
    import gf_pkg::*;

    localparam int M = GF_M;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [M-1:0] aIn;
    logic [M-1:0] bIn;
    logic [M-1:0] gIn;
    logic         outValid;
    logic         outReady;
    logic [M-1:0] pOut;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    logic [M-1:0] expQ[$];
    bit           randReady = 1'b0;
    int           n;
    int           pulses;

    gf_mult_seq_ctrl #(
        .M     (GF_M),
        .CNT_W (GF_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a_in      (aIn),
        .b_in      (bIn),
        .g_in      (gIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .p_out     (pOut),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Full carry-less product, then fold every x^i (i >= M) back in as x^(i-M)*g.
    function automatic logic [M-1:0] clmulRef(input logic [M-1:0] a, input logic [M-1:0] b,
                                              input logic [M-1:0] g);
        logic [2*M-1:0] prod;
        prod = '0;
        for (int i = 0; i < M; i++)
            if (b[i]) prod = prod ^ ({{M{1'b0}}, a} << i);
        for (int i = 2*M-2; i >= M; i--)
            if (prod[i]) begin
                prod    = prod ^ ({{M{1'b0}}, g} << (i - M));
                prod[i] = 1'b0;
            end
        return prod[M-1:0];
    endfunction

    // Single comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [M-1:0] actual,
                               input logic [M-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Unconditional failure, used for expired waits.
    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Present an operand set until accepted; record the model's result at the accept edge.
    task automatic applyStimulus(input logic [M-1:0] a, input logic [M-1:0] b,
                                 input logic [M-1:0] g);
        bit acc;
        acc     = 1'b0;
        inValid = 1'b1;
        aIn     = a;
        bIn     = b;
        gIn     = g;
        for (int w = 0; w < 400 && !acc; w++) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk);
            if (acc) expQ.push_back(clmulRef(a, b, g));
            #1;
        end
        inValid = 1'b0;
        if (!acc) failNow("accept_wait");
    endtask

    // Count negedges after the accept edge until out_valid is seen.
    task automatic waitValid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!outValid && cyc < 400);
        if (!outValid) failNow("valid_wait");
    endtask

    // Take the pending result with a one-cycle out_ready pulse.
    task automatic releaseResult();
        @(posedge clk); #1;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    // Directed operation with a hand-computed expected product.
    task automatic runOne(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g,
                          input logic [M-1:0] expLit, input string name, input bit checkLat);
        int cyc;
        applyStimulus(a, b, g);
        waitValid(cyc);
        if (checkLat) checkOutput({name, "_latency"}, cyc, M + 1);
        checkOutput(name, pOut, expLit);
        releaseResult();
    endtask

    // Random consumer backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (randReady) outReady = 1'(($urandom_range(0, 1)));
        end
    end

    // Per-cycle comparison of DUT outputs against the model's pending result.
    always @(negedge clk) begin
        if (!rst) begin
            if (outValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_valid actual=1 required=0");
                end else begin
                    checkOutput("model_p_out", pOut, expQ[0]);
                    checkOutput("valid_busy", busy, 1);
                    checkOutput("done_in_ready", inReady, outReady);
                    if (outReady) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("idle_p_out", pOut, '0);
            end
        end
    end

    // Directed scenarios followed by randomized operands.
    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        aIn      = '0;
        bIn      = '0;
        gIn      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", inReady, 1);
        checkOutput("post_rst_p_out", pOut, '0);

        checkOutput("pin_identity", clmulRef(32'h1, 32'h1, GF_POLY_DEFAULT), 32'h1);
        checkOutput("pin_reduce", clmulRef(32'h2, 32'h8000_0000, GF_POLY_DEFAULT), 32'hAF);
        checkOutput("pin_small", clmulRef(32'h3, 32'h5, GF_POLY_DEFAULT), 32'hF);
        checkOutput("pin_g_zero", clmulRef(32'h8000_0001, 32'h3, 32'h0), 32'h8000_0003);

        @(posedge clk); #1;
        runOne(32'h1, 32'h1, GF_POLY_DEFAULT, 32'h1, "identity", 1'b1);
        runOne(32'h2, 32'h8000_0000, GF_POLY_DEFAULT, 32'hAF, "reduction", 1'b0);
        runOne(32'hFFFF_FFFF, 32'h1, GF_POLY_DEFAULT, 32'hFFFF_FFFF, "all_ones", 1'b0);
        runOne(32'h1234_5678, 32'h0, GF_POLY_DEFAULT, 32'h0, "b_zero", 1'b0);
        runOne(32'h0, 32'hDEAD_BEEF, GF_POLY_DEFAULT, 32'h0, "a_zero", 1'b0);
        runOne(32'h2, 32'h8000_0000, 32'h0, 32'h0, "g_zero_wrap", 1'b0);
        runOne(32'h8000_0001, 32'h3, 32'h0, 32'h8000_0003, "g_zero_mix", 1'b0);

        // Backpressure: result and flags hold while the consumer stalls.
        applyStimulus(32'h3, 32'h5, GF_POLY_DEFAULT);
        waitValid(n);
        checkOutput("bp_first", pOut, 32'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_valid_hold", outValid, 1);
            checkOutput("bp_p_hold", pOut, 32'hF);
            checkOutput("bp_in_ready", inReady, 0);
        end

        // Back-to-back: release and accept in the same cycle.
        @(posedge clk); #1;
        outReady = 1'b1;
        applyStimulus(32'h8000_0000, 32'h2, GF_POLY_DEFAULT);
        outReady = 1'b0;
        waitValid(n);
        checkOutput("b2b_latency", n, M + 1);
        checkOutput("b2b_result", pOut, 32'hAF);
        releaseResult();

        // Reset at RUN step 10 discards the operation.
        applyStimulus(32'h5, 32'h7, GF_POLY_DEFAULT);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        expQ.delete();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", inReady, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", outValid, 0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (outValid) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        @(posedge clk); #1;
        runOne(32'h5, 32'h7, GF_POLY_DEFAULT, 32'h1B, "after_abort", 1'b1);

        // Operand changes during RUN must not affect the result.
        applyStimulus(32'h3, 32'h5, GF_POLY_DEFAULT);
        for (int k = 0; k < 12; k++) begin
            inValid = (k % 2 == 0);
            aIn     = $urandom;
            bIn     = $urandom;
            gIn     = $urandom;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        waitValid(n);
        checkOutput("busy_ignore", pOut, 32'hF);
        releaseResult();

        // Random operands with random consumer backpressure.
        randReady = 1'b1;
        for (int i = 0; i < 1000; i++)
            applyStimulus($urandom, $urandom, (i % 10 == 0) ? 32'h0 : $urandom);
        for (int w = 0; w < 2000 && expQ.size() > 0; w++)
            @(posedge clk);
        if (expQ.size() > 0) failNow("drain");
        randReady = 1'b0;
        @(posedge clk); #1;
        outReady = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
